// File: rtl/loader_pkg.sv
// Shared types and constants for the BRAM program loader.
package loader_pkg;

  // Loader phases: header collection, word loading, and the two terminal states.
  typedef enum logic [1:0] {
    L_HDR,
    L_DATA,
    L_DONE,
    L_ERR
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = BYTES_PER_WORD * 8;

endpackage

// File: rtl/bram_loader_if.sv
// Byte-stream input and BRAM write-port/status bundle of the program loader.
// The loader is the initiator on the BRAM port, so it takes the master view.
interface bram_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_di;
  logic              busy;
  logic              done;
  logic              err;

  // Loader side: consumes UART bytes, drives the BRAM write port and status.
  modport master (
    input  rx_valid,
    input  rx_data,
    output bram_we,
    output bram_addr,
    output bram_di,
    output busy,
    output done,
    output err
  );

  // Environment side: UART receiver feeding bytes, BRAM and core observing.
  modport slave (
    output rx_valid,
    output rx_data,
    input  bram_we,
    input  bram_addr,
    input  bram_di,
    input  busy,
    input  done,
    input  err
  );

endinterface

// File: rtl/byte_packer.sv
// Packs a byte stream into little-endian words. The completed word and its
// strobe are presented combinationally in the cycle of the last byte, so the
// consumer can register the write one cycle later without stalling input.
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  localparam int                IDX_W = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0]  idx;
  logic [WORD_W-9:0] asm_r;

  // The top byte never needs storing: it is the byte arriving right now.
  assign word_valid = rx_valid && !clear && (idx == LAST);
  assign word       = {rx_data, asm_r};

  // Byte index and lower-byte assembly register; only accepted strobes advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      asm_r <= '0;
    end else if (clear) begin
      idx   <= '0;
      asm_r <= '0;
    end else if (rx_valid) begin
      for (int k = 0; k < BYTES_PER_WORD - 1; k++) begin
        if (idx == IDX_W'(k)) begin
          asm_r[8*k +: 8] <= rx_data;
        end
      end
      idx <= (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/bram_loader.sv
// Program loader: parses a 4-byte little-endian word count from the UART
// byte stream, then writes that many little-endian words to BRAM from
// address 0 upward. Owns the BRAM write port until done.
module bram_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  bram_loader_if.master bus
);

  // Word index is one bit wider than the address so a full-capacity load
  // (N = 2**ADDR_W) can be counted to completion.
  localparam int          CNT_W    = ADDR_W + 1;
  localparam logic [32:0] CAPACITY = 33'(1) << ADDR_W;

  loader_state_t     state;
  logic [CNT_W-1:0]  widx;
  logic [CNT_W-1:0]  wtotal;
  logic [CNT_W-1:0]  widx_nxt;

  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              pk_clear;

  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] di_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;

  function automatic logic hdr_over_capacity(input logic [WORD_W-1:0] n);
    return {1'b0, n} > CAPACITY;
  endfunction

  // Terminal states hold the packer idle so late bytes cannot form words.
  assign pk_clear = (state == L_DONE) || (state == L_ERR);
  assign widx_nxt = widx + 1'b1;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .rx_valid   (bus.rx_valid),
    .rx_data    (bus.rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // Loader FSM with registered BRAM write port and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= L_HDR;
      widx   <= '0;
      wtotal <= '0;
      we_r   <= 1'b0;
      addr_r <= '0;
      di_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      we_r <= 1'b0;
      unique case (state)
        L_HDR: begin
          if (word_valid) begin
            if (word == '0) begin
              state  <= L_DONE;
              done_r <= 1'b1;
            end else if (hdr_over_capacity(word)) begin
              state <= L_ERR;
              err_r <= 1'b1;
            end else begin
              state  <= L_DATA;
              wtotal <= word[CNT_W-1:0];
              widx   <= '0;
              busy_r <= 1'b1;
            end
          end
        end
        L_DATA: begin
          if (word_valid) begin
            we_r   <= 1'b1;
            addr_r <= widx[ADDR_W-1:0];
            di_r   <= DATA_W'(word);
            widx   <= widx_nxt;
            // Leave now so trailing bytes are ignored; done/busy flip one
            // cycle later, after the final write pulse has been presented.
            if (widx_nxt == wtotal) begin
              state <= L_DONE;
            end
          end
        end
        L_DONE: begin
          if (busy_r) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        L_ERR: begin
        end
        default: begin
          state <= L_HDR;
        end
      endcase
    end
  end

  assign bus.bram_we   = we_r;
  assign bus.bram_addr = addr_r;
  assign bus.bram_di   = di_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_bram_loader.sv
// Bench for bram_loader: header classification table plus directed and
// randomized loads checked against a byte-stream reference model.
module tb_bram_loader;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int CAP = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  bram_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bram_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [31:0] n;
    bit          busy;
    bit          done;
    bit          err;
  } hvec_t;

  int          ntests   = 0;
  int          nfail    = 0;
  int          cyc      = 0;
  wr_t         wq[$];
  logic [7:0]  stim[$];
  int          bcyc[$];
  int          done_cyc = -1;
  int          err_cyc  = -1;
  bit          have_w   = 1'b0;
  bit          prev_we  = 1'b0;
  logic [AW-1:0] last_a;
  logic [DW-1:0] last_d;
  hvec_t       tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Write capture and per-cycle protocol checks.
  always @(negedge clk) begin
    if (rst) begin
      have_w  = 1'b0;
      prev_we = 1'b0;
    end else begin
      if (bus.bram_we) begin
        chk("we_single_cycle", 64'(prev_we), 64'd0);
        chk("busy_during_write", 64'(bus.busy), 64'd1);
        wq.push_back('{int'(bus.bram_addr), bus.bram_di, cyc});
        last_a = bus.bram_addr;
        last_d = bus.bram_di;
        have_w = 1'b1;
      end else if (have_w) begin
        chk("addr_hold", 64'(bus.bram_addr), 64'(last_a));
        chk("di_hold", 64'(bus.bram_di), 64'(last_d));
      end
      if (bus.done && done_cyc < 0) begin
        done_cyc = cyc;
        chk("busy_at_done", 64'(bus.busy), 64'd0);
      end
      if (bus.err && err_cyc < 0) err_cyc = cyc;
      prev_we = bus.bram_we;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Asserts reset between clock edges, checks outputs cleared asynchronously.
  task automatic do_reset();
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    #1;
    chk("reset_outputs",
        64'({bus.bram_we, bus.busy, bus.done, bus.err, bus.bram_addr, bus.bram_di}), 64'd0);
    wq.delete();
    bcyc.delete();
    done_cyc = -1;
    err_cyc  = -1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    stim.push_back(w[7:0]);
    stim.push_back(w[15:8]);
    stim.push_back(w[23:16]);
    stim.push_back(w[31:24]);
  endtask

  // Drives stim[] with random idle gaps; ends one cycle after the last byte
  // plus tail extra cycles.
  task automatic run_stream(input int maxgap, input int tail);
    for (int i = 0; i < stim.size(); i++) begin
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (gap) begin
        @(negedge clk);
        bus.rx_valid = 1'b0;
      end
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = stim[i];
      bcyc.push_back(cyc);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (tail) @(negedge clk);
  endtask

  // Reference: interpret stim[] as header + words and derive writes and flags.
  task automatic check_model(input string nm);
    logic [31:0] n;
    int nw;
    int nexp;
    int exp_done;
    int exp_err;
    bit exp_busy;
    n        = {stim[3], stim[2], stim[1], stim[0]};
    nw       = (stim.size() - 4) / 4;
    nexp     = 0;
    exp_done = -1;
    exp_err  = -1;
    exp_busy = 1'b0;
    if (n == 32'd0) begin
      exp_done = bcyc[3] + 1;
    end else if (n > 32'(CAP)) begin
      exp_err = bcyc[3] + 1;
    end else begin
      int nn;
      nn   = int'(n);
      nexp = (nw < nn) ? nw : nn;
      if (nw >= nn) exp_done = bcyc[4*nn + 3] + 2;
      else exp_busy = 1'b1;
    end
    chk({nm, " nwrites"}, 64'(wq.size()), 64'(nexp));
    for (int k = 0; k < nexp && k < wq.size(); k++) begin
      int b;
      b = 4 + 4*k;
      chk({nm, " addr"}, 64'(wq[k].addr), 64'(k));
      chk({nm, " data"}, 64'(wq[k].data), 64'({stim[b+3], stim[b+2], stim[b+1], stim[b]}));
      chk({nm, " wcycle"}, 64'(wq[k].cyc), 64'(bcyc[b+3] + 1));
    end
    chk({nm, " done_cycle"}, 64'(done_cyc), 64'(exp_done));
    chk({nm, " err_cycle"}, 64'(err_cyc), 64'(exp_err));
    chk({nm, " busy"}, 64'(bus.busy), 64'(exp_busy));
    chk({nm, " done"}, 64'(bus.done), 64'(exp_done >= 0));
    chk({nm, " err"}, 64'(bus.err), 64'(exp_err >= 0));
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    tbl[0] = '{32'h0000_0000, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{32'h0000_0401, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{32'h0000_0400, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{32'h0000_0001, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{32'h0001_0000, 1'b0, 1'b0, 1'b1};

    @(negedge clk);
    do_reset();

    // Header classification, flags one cycle after the 4th header byte.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      stim.delete();
      push_word(tbl[i].n);
      run_stream(0, 0);
      chk($sformatf("hdr%0d busy", i), 64'(bus.busy), 64'(tbl[i].busy));
      chk($sformatf("hdr%0d done", i), 64'(bus.done), 64'(tbl[i].done));
      chk($sformatf("hdr%0d err", i), 64'(bus.err), 64'(tbl[i].err));
      chk($sformatf("hdr%0d we", i), 64'(bus.bram_we), 64'd0);
    end

    // Two words back-to-back.
    do_reset();
    stim.delete();
    push_word(32'd2);
    push_word(32'h1234_5678);
    push_word(32'hDEAD_BEEF);
    run_stream(0, 6);
    check_model("b2b");
    if (wq.size() == 2) begin
      chk("b2b word0", 64'(wq[0].data), 64'h1234_5678);
      chk("b2b word1", 64'(wq[1].data), 64'hDEAD_BEEF);
    end

    // N=0 with trailing bytes.
    do_reset();
    stim.delete();
    push_word(32'd0);
    push_word($urandom);
    push_word($urandom);
    run_stream(0, 4);
    check_model("n0");

    // N=1025 rejected, trailing bytes ignored.
    do_reset();
    stim.delete();
    push_word(32'd1025);
    push_word($urandom);
    push_word($urandom);
    run_stream(2, 4);
    check_model("n1025");

    // N=3 with random gaps.
    do_reset();
    stim.delete();
    push_word(32'd3);
    for (int k = 0; k < 3; k++) push_word($urandom);
    stim.push_back(8'hA5);
    run_stream(7, 8);
    check_model("n3gaps");

    // Random loads, including trailing bytes.
    for (int r = 0; r < 6; r++) begin
      int n;
      int trail;
      n     = int'($urandom_range(1, 8));
      trail = int'($urandom_range(0, 5));
      do_reset();
      stim.delete();
      push_word(32'(n));
      for (int k = 0; k < n; k++) push_word($urandom);
      for (int k = 0; k < trail; k++) stim.push_back(8'($urandom));
      run_stream(int'($urandom_range(0, 3)), 6);
      check_model($sformatf("rand%0d", r));
    end

    // Incomplete load stays busy.
    do_reset();
    stim.delete();
    push_word(32'd5);
    for (int k = 0; k < 3; k++) push_word($urandom);
    run_stream(1, 6);
    check_model("partial5");

    // Reset after 2 bytes of word 1, then a fresh N=1 load.
    do_reset();
    stim.delete();
    push_word(32'd4);
    push_word($urandom);
    stim.push_back(8'h5A);
    stim.push_back(8'hC3);
    run_stream(0, 3);
    check_model("midload");
    do_reset();
    stim.delete();
    push_word(32'd1);
    push_word(32'h4433_2211);
    run_stream(0, 6);
    check_model("postrst");
    if (wq.size() == 1) begin
      chk("postrst word", 64'(wq[0].data), 64'h4433_2211);
      chk("postrst addr", 64'(wq[0].addr), 64'd0);
    end

    // Reset asserted during the write pulse itself.
    do_reset();
    stim.delete();
    push_word(32'd2);
    push_word(32'hCAFE_F00D);
    run_stream(0, 0);
    chk("pulse we_before_rst", 64'(bus.bram_we), 64'd1);
    do_reset();
    stim.delete();
    push_word(32'd1);
    push_word($urandom);
    run_stream(0, 6);
    check_model("afterpulse");

    // Full-capacity load, word value equals its index.
    do_reset();
    stim.delete();
    push_word(32'd1024);
    for (int k = 0; k < CAP; k++) push_word(32'(k));
    push_word(32'hFFFF_FFFF);
    run_stream(0, 6);
    check_model("full");
    if (wq.size() == CAP) begin
      chk("full last addr", 64'(wq[CAP-1].addr), 64'd1023);
      chk("full last data", 64'(wq[CAP-1].data), 64'h3FF);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/bram_loader.md
# bram_loader

Program loader that fills the single-port instruction/data BRAM from a UART receive byte stream before the core starts. It parses a 4-byte little-endian word-count header, packs each following 4 bytes into a 32-bit little-endian word, and writes the words to consecutive BRAM addresses starting at 0. It is the writing initiator on the BRAM's clk/we/addr/di port and owns that port until `done`, when the core takes over.

## Interface
- `ADDR_W`, default 10: BRAM address width; capacity is 2**ADDR_W words.
- `DATA_W`, default 32: BRAM word width; fixed at 4 bytes.
- `clk`  in  1: single clock; shared with the BRAM.
- `rst`  in  1: asynchronous, active-high reset.
- `rx_valid`  in  1: one-cycle strobe; `rx_data` is valid this cycle.
- `rx_data`  in  8: received byte.
- `bram_we`  out  1: BRAM write enable; a one-cycle pulse per word.
- `bram_addr`  out  ADDR_W: BRAM word address.
- `bram_di`  out  DATA_W: BRAM write data.
- `busy`  out  1: header accepted with N>0, load in progress.
- `done`  out  1: all N words written; sticky until reset.
- `err`  out  1: header N exceeds capacity; sticky until reset.

## Operation
- States:
  - `L_HDR`: collect 4 header bytes into count N (32-bit, little-endian).
  - `L_DATA`: collect words and write them.
  - `L_DONE`: load complete.
  - `L_ERR`: header rejected.
- Reset enters `L_HDR`. All outputs are 0 and the byte index, word index and assembly register are cleared. BRAM contents are untouched.
- Byte packing: the k-th byte of a group (k=0..3) lands in bits [8k+7:8k]. The byte index counts accepted `rx_valid` strobes only and wraps 3→0.
- `L_HDR` exit, on the 4th header byte:
  - N=0 → `L_DONE`.
  - N > 2**ADDR_W → `L_ERR`.
  - otherwise → `L_DATA` with word index 0.
- `L_DATA`: on the 4th byte of a word, a write is issued for the current word index, and the word index increments. After the N-th word is written → `L_DONE`.
- `L_DONE` and `L_ERR` ignore all further `rx_valid`. They leave only on `rst`.
- `bram_addr` holds the last written address between writes. `bram_di` holds the last word.
- Word index width is ADDR_W+1, so N = 2**ADDR_W is legal. Writes use the low ADDR_W bits, and the last address is 2**ADDR_W−1.

## Timing
- Write latency: if the 4th byte of a word arrives at cycle t, then `bram_we`=1 at t+1 with `bram_addr`/`bram_di` valid in that same cycle. `bram_we` returns to 0 at t+2 unless another word completes.
- Input rate: back-to-back `rx_valid` on every cycle is supported with no stall and no byte loss. The packing register is separate from the registered write outputs, so the minimum spacing between writes is 4 cycles.
- `busy`: 1 from the cycle after a valid nonzero header completes, through the final write cycle. 0 in all other states.
- `done`:
  - N>0: 1 from the cycle after the final write (t+2 relative to the last byte).
  - N=0: 1 at t+1 relative to the 4th header byte.
- `err`: 1 at t+1 relative to the 4th header byte. `bram_we` never pulses in the error case.
- Reset mid-load (including the write-pulse cycle): all outputs go to 0 asynchronously and the FSM returns to `L_HDR`. A partial word is discarded and the next byte is treated as header byte 0.

## Structure
- Package `loader_pkg`: `loader_state_t` enum {`L_HDR`, `L_DATA`, `L_DONE`, `L_ERR`}, and `BYTES_PER_WORD`=4.
- Sub-module `byte_packer`: takes `rx_valid`/`rx_data`, produces a 32-bit word plus a one-cycle `word_valid`, with a synchronous `clear` input. The same packer serves both the header and the data words.
- The FSM, counters and registered BRAM outputs live in `bram_loader`.

## Test plan
- Header 02 00 00 00, then data 78 56 34 12 EF BE AD DE, all back-to-back → writes addr0=0x12345678 then addr1=0xDEADBEEF, each as a single-cycle `bram_we`. `done`=1 two cycles after the last byte; `busy`=0 at that point.
- Header 00 00 00 00 → no `bram_we`; `done`=1 one cycle after the 4th byte. Trailing bytes are ignored.
- Header 01 04 00 00 (N=1025) → `err`=1 one cycle after the 4th byte. No writes occur, `done` stays 0, and subsequent bytes are ignored.
- Header N=3, with data bytes separated by random 0–7 idle cycles → three writes to addr 0,1,2 with the correct words. `bram_addr`/`bram_di` are held between writes.
- N=4; assert `rst` after 2 bytes of word 1; then send a new header N=1 and 11 22 33 44 → every output is 0 during reset, and the only post-reset write is addr0=0x44332211.
- Header 00 04 00 00 (N=1024), with word value equal to its index → final write goes to addr 1023 with value 0x3FF. `done`=1 and `err`=0.
